// File: rtl/water_pkg.sv
// Shared types and widths for the drink reminder scheduler.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package water_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        ALERT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    localparam int SECS_W  = 12;
    localparam int LEVEL_W = 4;

    function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] v,
                                                   input logic [LEVEL_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/water_sched_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; clr restarts the count.
// Latency: tick is combinational on the prescaler value; clr takes effect on the next edge.
// Backpressure: none, free running.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/water_sched.sv
// Drink reminder: interval countdown with alert, saturating level count, frame-synchronous level.
// Latency: drink counted on the 3rd edge after it rises; water_level follows at the next frame start.
// Backpressure: none; a drink in DONE is dropped, clear_day always wins.
module water_sched
    import water_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int INTERVAL_S = 1800,
    parameter int MAX_LEVEL  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               drink,
    input  logic               clear_day,
    input  logic               vsync,
    output logic [LEVEL_W-1:0] water_level,
    output logic               remainder,
    output logic               alert,
    output logic [SECS_W-1:0]  secs_left,
    output logic [1:0]         state
);

    localparam logic [SECS_W-1:0]  INTERVAL = SECS_W'(INTERVAL_S);
    localparam logic [LEVEL_W-1:0] MAX_LV   = LEVEL_W'(MAX_LEVEL);

    logic drink_s1, drink_s2, drink_s3, drink_p;
    logic vs_q, frame_start;
    logic tick, reload;

    sched_state_t       state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d, level_inc;
    logic [SECS_W-1:0]  secs_q, secs_d;
    logic               rem_q, rem_d;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (reload),
        .tick  (tick)
    );

    // drink is asynchronous: two flops for metastability, a third for the edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drink_s1 <= 1'b0;
            drink_s2 <= 1'b0;
            drink_s3 <= 1'b0;
            vs_q     <= 1'b1;
        end else begin
            drink_s1 <= drink;
            drink_s2 <= drink_s1;
            drink_s3 <= drink_s2;
            vs_q     <= vsync;
        end
    end

    assign drink_p     = drink_s2 & ~drink_s3;
    assign frame_start = vs_q & ~vsync;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        secs_d    = secs_q;
        rem_d     = rem_q;
        reload    = 1'b0;
        level_inc = sat_inc(level_q, MAX_LV);

        if (clear_day) begin
            level_d = '0;
            state_d = COUNT;
            rem_d   = 1'b0;
            reload  = 1'b1;
        end else begin
            case (state_q)
                COUNT, ALERT: begin
                    // a drink restarts the interval, so a coincident tick is dropped
                    if (drink_p) begin
                        level_d = level_inc;
                        reload  = 1'b1;
                        rem_d   = 1'b0;
                        state_d = (level_inc == MAX_LV) ? DONE : COUNT;
                    end else if (tick) begin
                        if (state_q == ALERT) begin
                            rem_d = ~rem_q;
                        end else if (secs_q <= SECS_W'(1)) begin
                            secs_d  = '0;
                            state_d = ALERT;
                            rem_d   = 1'b1;
                        end else begin
                            secs_d = secs_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    secs_d = '0;
                    rem_d  = 1'b0;
                end
                default: state_d = COUNT;
            endcase
        end

        if (reload) begin
            secs_d = INTERVAL;
        end
        if (state_d == DONE) begin
            secs_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COUNT;
            level_q     <= '0;
            secs_q      <= INTERVAL;
            rem_q       <= 1'b0;
            water_level <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            secs_q  <= secs_d;
            rem_q   <= rem_d;
            if (frame_start) begin
                water_level <= level_q;
            end
        end
    end

    assign state     = state_q;
    assign alert     = (state_q == ALERT);
    assign remainder = rem_q;
    assign secs_left = secs_q;

endmodule

// File: doc/water_sched.md
Name: water_sched

Overview:
- Reminder scheduler and controller for the water-level display path.
- Counts down a drink interval in seconds and raises an alert when it expires.
- Counts drink events into a saturating 4-bit water level.
- Presents water_level and the remainder blink bit to videoGen, updating water_level only at frame start (vsync falling edge) so a frame never shows a torn bar.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per 1 s tick.
- INTERVAL_S, 1800: reminder interval in seconds; legal range 1..4095.
- MAX_LEVEL, 15: level at which reminders stop; legal range 1..15.

Ports:
- clk, input, 1: system clock (50 MHz).
- reset, input, 1: asynchronous, active-low reset; asserted when 0.
- drink, input, 1: raw button level, asynchronous; one count per rising edge.
- clear_day, input, 1: synchronous level input, one-cycle or longer; restarts the day.
- vsync, input, 1: active-low vsync from vgaController.
- water_level, output, 4: frame-synchronous level to videoGen.
- remainder, output, 1: alert blink bit to videoGen.
- alert, output, 1: high while in ALERT.
- secs_left, output, 12: seconds remaining in the current interval.
- state, output, 2: current FSM state.

Behaviour:
- Reset values (reset=0, asynchronous):
  - state=COUNT, water_level=0, internal level=0.
  - alert=0, remainder=0.
  - secs_left=INTERVAL_S, prescaler=0, synchronizer flops=0.
  - vsync register=1.
- Drink input path:
  - drink passes through a 2-flop synchronizer, then a rising-edge detect, producing a one-cycle drink_p.
  - The internal level updates on the 3rd rising clk edge after drink first meets setup high.
  - Holding drink high yields exactly one count.
- Tick generation:
  - tick is a one-cycle pulse when the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - A "reload" clears the prescaler and sets secs_left=INTERVAL_S, so every interval is exact.
- FSM states (2-bit encoding):
  - COUNT=0: on tick, secs_left decrements. On a tick with secs_left==1: secs_left=0, go to ALERT.
  - ALERT=1:
    - On entry, alert=1 and remainder=1.
    - remainder toggles on each tick.
    - secs_left holds at 0; no re-arm.
  - DONE=2: no countdown; secs_left=0, alert=0, remainder=0; drink_p is ignored.
  - 3: unused; return to COUNT.
- drink_p in COUNT or ALERT:
  - level=level+1, then reload.
  - Next state is DONE if the new level==MAX_LEVEL, else COUNT.
  - Leaving ALERT clears alert and remainder on the same edge.
- clear_day, in any state: level=0, reload, state=COUNT, alert=0, remainder=0.
- Simultaneous events:
  - clear_day has priority over drink_p; the drink is discarded.
  - drink_p has priority over tick; a tick in the same cycle is discarded, so the interval restarts full.
- Level arithmetic is 4-bit saturating at MAX_LEVEL and never wraps.
- Frame-synchronous level update:
  - vsync is registered into vs_q.
  - frame_start = vs_q & ~vsync.
  - On frame_start, water_level <= internal level; otherwise water_level holds.
- Reset asserted mid-operation (e.g. in ALERT): all outputs take their reset values immediately, without waiting for a clk edge.

Decomposition:
- Package water_pkg holds:
  - typedef enum logic [1:0] {COUNT, ALERT, DONE} sched_state_t;
  - localparam SECS_W=12 and LEVEL_W=4.
- One sub-module, tick_gen: a prescaler with a clear input and a tick output, parameterised by TICK_DIV.
- The synchronizer, FSM, level counter and frame latch stay in water_sched.

Test Plan:
All scenarios use TICK_DIV=4, INTERVAL_S=3, MAX_LEVEL=15, with vsync pulsing low every 20 cycles.
1. Reset then release, no inputs → state=COUNT, secs_left steps 3,2,1 one tick (4 clk) apart; alert=1 and state=ALERT on the 3rd tick; remainder toggles every 4 clk thereafter; secs_left=0.
2. drink high for 10 clk while in ALERT → exactly one count: internal level=1; alert=0 and remainder=0 on the same edge; secs_left=3; water_level stays 0 until the next vsync falling edge, then becomes 1 one clk later.
3. Fifteen separated drink pulses → state=DONE after the 15th; water_level=15 after the next frame start; a 16th drink leaves the level at 15; no alert over 20 ticks.
4. From level 7 in COUNT, clear_day and drink_p in the same cycle → level=0, state=COUNT, secs_left=3; the drink is not counted.
5. drink_p coincident with a tick at secs_left==1 → no ALERT; level+1; secs_left=3.
6. reset driven low mid-ALERT, between clk edges → alert, remainder and water_level are 0 immediately; after release, state=COUNT and secs_left=3.
